// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - stall/forward scheduler for the 5-stage MIPS pipeline
// Decodes the D-stage instruction and tracks A3/Tnew/rs/rt through E, M and W.
module hazard_sched #(
  parameter logic [4:0] RA_REG  = 5'd31,
  parameter logic [1:0] LW_TNEW = 2'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_d,
  output logic        stall,
  output logic        flush_e,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  logic [5:0] op, fn;
  logic [4:0] rs_f, rt_f, rd_f;

  assign op   = ins_d[31:26];
  assign rs_f = ins_d[25:21];
  assign rt_f = ins_d[20:16];
  assign rd_f = ins_d[15:11];
  assign fn   = ins_d[5:0];

  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt, tnew_dec;
  logic [4:0] a3_dec;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    tuse_rs  = 2'd0;
    tuse_rt  = 2'd0;
    tnew_dec = 2'd0;
    a3_dec   = 5'd0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            use_rs = 1'b1; tuse_rs = 2'd1;
            use_rt = 1'b1; tuse_rt = 2'd1;
            tnew_dec = 2'd1; a3_dec = rd_f;
          end
          FN_SLL: begin
            use_rt = 1'b1; tuse_rt = 2'd1;
            tnew_dec = 2'd1; a3_dec = rd_f;
          end
          FN_JR: begin
            use_rs = 1'b1; tuse_rs = 2'd0;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        use_rs = 1'b1; tuse_rs = 2'd1;
        tnew_dec = 2'd1; a3_dec = rt_f;
      end
      OP_LUI: begin
        tnew_dec = 2'd1; a3_dec = rt_f;
      end
      OP_LW: begin
        use_rs = 1'b1; tuse_rs = 2'd1;
        tnew_dec = LW_TNEW; a3_dec = rt_f;
      end
      OP_SW: begin
        use_rs = 1'b1; tuse_rs = 2'd1;
        use_rt = 1'b1; tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_JAL: begin
        tnew_dec = 2'd0; a3_dec = RA_REG;
      end
      default: ;
    endcase
  end

  logic [4:0] a3_e_q, a3_m_q, a3_w_q;
  logic [1:0] tnew_e_q, tnew_m_q, tnew_w_q;
  logic [4:0] rs_e_q, rs_m_q, rs_w_q;
  logic [4:0] rt_e_q, rt_m_q, rt_w_q;

  logic [4:0] a3_e_d, rs_e_d, rt_e_d;
  logic [1:0] tnew_e_d, tnew_m_d, tnew_w_d;

  logic hz_rs, hz_rt;

  assign hz_rs = use_rs && (rs_f != 5'd0) &&
                 (((a3_e_q == rs_f) && (tuse_rs < tnew_e_q)) ||
                  ((a3_m_q == rs_f) && (tuse_rs < tnew_m_q)));
  assign hz_rt = use_rt && (rt_f != 5'd0) &&
                 (((a3_e_q == rt_f) && (tuse_rt < tnew_e_q)) ||
                  ((a3_m_q == rt_f) && (tuse_rt < tnew_m_q)));

  assign stall   = hz_rs | hz_rt;
  assign flush_e = stall;

  // Unused operand fields are carried as $0 so they can never raise a select.
  assign a3_e_d   = stall ? 5'd0 : a3_dec;
  assign tnew_e_d = stall ? 2'd0 : tnew_dec;
  assign rs_e_d   = (stall || !use_rs) ? 5'd0 : rs_f;
  assign rt_e_d   = (stall || !use_rt) ? 5'd0 : rt_f;
  assign tnew_m_d = (tnew_e_q != 2'd0) ? tnew_e_q - 2'd1 : 2'd0;
  assign tnew_w_d = (tnew_m_q != 2'd0) ? tnew_m_q - 2'd1 : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e_q <= 5'd0; tnew_e_q <= 2'd0; rs_e_q <= 5'd0; rt_e_q <= 5'd0;
      a3_m_q <= 5'd0; tnew_m_q <= 2'd0; rs_m_q <= 5'd0; rt_m_q <= 5'd0;
      a3_w_q <= 5'd0; tnew_w_q <= 2'd0; rs_w_q <= 5'd0; rt_w_q <= 5'd0;
    end else begin
      a3_e_q <= a3_e_d; tnew_e_q <= tnew_e_d; rs_e_q <= rs_e_d; rt_e_q <= rt_e_d;
      a3_m_q <= a3_e_q; tnew_m_q <= tnew_m_d; rs_m_q <= rs_e_q; rt_m_q <= rt_e_q;
      a3_w_q <= a3_m_q; tnew_w_q <= tnew_w_d; rs_w_q <= rs_m_q; rt_w_q <= rt_m_q;
    end
  end

  // Nearest producer wins; a stage still computing its result is skipped.
  assign fwd_rs_d = (rs_f == 5'd0)                              ? 2'd0 :
                    ((a3_e_q == rs_f) && (tnew_e_q == 2'd0))    ? 2'd1 :
                    ((a3_m_q == rs_f) && (tnew_m_q == 2'd0))    ? 2'd2 :
                    (a3_w_q == rs_f)                            ? 2'd3 : 2'd0;
  assign fwd_rt_d = (rt_f == 5'd0)                              ? 2'd0 :
                    ((a3_e_q == rt_f) && (tnew_e_q == 2'd0))    ? 2'd1 :
                    ((a3_m_q == rt_f) && (tnew_m_q == 2'd0))    ? 2'd2 :
                    (a3_w_q == rt_f)                            ? 2'd3 : 2'd0;

  assign fwd_rs_e = (rs_e_q == 5'd0)                            ? 2'd0 :
                    ((a3_m_q == rs_e_q) && (tnew_m_q == 2'd0))  ? 2'd2 :
                    (a3_w_q == rs_e_q)                          ? 2'd3 : 2'd0;
  assign fwd_rt_e = (rt_e_q == 5'd0)                            ? 2'd0 :
                    ((a3_m_q == rt_e_q) && (tnew_m_q == 2'd0))  ? 2'd2 :
                    (a3_w_q == rt_e_q)                          ? 2'd3 : 2'd0;

  assign fwd_rt_m = (rt_m_q != 5'd0) && (rt_m_q == a3_w_q);

  logic unused_bits;
  assign unused_bits = ^{ins_d[10:6], tnew_w_q, rs_m_q, rs_w_q, rt_w_q};

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - directed self-checking bench for hazard_sched
module tb_hazard_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins_d;
  logic        stall, flush_e, fwd_rt_m;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int n_cmp = 0;
  int n_err = 0;

  hazard_sched dut (
    .clk      (clk),
    .reset    (reset),
    .ins_d    (ins_d),
    .stall    (stall),
    .flush_e  (flush_e),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JAL = {6'h03, 26'h0000100};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    ins_d = NOP;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ins_d = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0b want 0", stall); end
    n_cmp++; if (flush_e !== 1'b0) begin n_err++; $display("FAIL rst_flush got %0b want 0", flush_e); end
    n_cmp++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 9'd0) begin
      n_err++; $display("FAIL rst_fwd got %b want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
    end
    @(negedge clk);
    reset = 1'b1;
    ins_d = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
    tick();
    ins_d = r_ins(5'd1, 5'd1, 5'd2, 6'h21);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall got %0b want 1", stall); end
    reset = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got %0b want 0", stall); end
    reset = 1'b1;
    ins_d = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_post_addu got %0b want 0", stall); end
    drain();
  endtask

  task automatic test_lw_use;
    ins_d = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lwuse_c0 stall got %0b want 0", stall); end
    tick();
    ins_d = r_ins(5'd1, 5'd1, 5'd2, 6'h21);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lwuse_stall got %0b want 1", stall); end
    n_cmp++; if (flush_e !== 1'b1) begin n_err++; $display("FAIL lwuse_flush got %0b want 1", flush_e); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lwuse_release got %0b want 0", stall); end
    tick();
    ins_d = NOP;
    #1;
    n_cmp++; if (fwd_rs_e !== 2'd3) begin n_err++; $display("FAIL lwuse_fwd_rs_e got %0d want 3", fwd_rs_e); end
    n_cmp++; if (fwd_rt_e !== 2'd3) begin n_err++; $display("FAIL lwuse_fwd_rt_e got %0d want 3", fwd_rt_e); end
    drain();
  endtask

  task automatic test_lw_branch;
    ins_d = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
    tick();
    ins_d = i_ins(6'h04, 5'd1, 5'd0, 16'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lwbeq_stall1 got %0b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lwbeq_stall2 got %0b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lwbeq_release got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd3) begin n_err++; $display("FAIL lwbeq_fwd_rs_d got %0d want 3", fwd_rs_d); end
    n_cmp++; if (fwd_rt_d !== 2'd0) begin n_err++; $display("FAIL lwbeq_fwd_rt_d got %0d want 0", fwd_rt_d); end
    drain();
  endtask

  task automatic test_alu_branch;
    ins_d = r_ins(5'd1, 5'd2, 5'd5, 6'h21);
    tick();
    ins_d = i_ins(6'h04, 5'd5, 5'd0, 16'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL alubeq_stall got %0b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alubeq_release got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd2) begin n_err++; $display("FAIL alubeq_fwd_rs_d got %0d want 2", fwd_rs_d); end
    drain();
    ins_d = r_ins(5'd1, 5'd2, 5'd6, 6'h23);
    tick();
    ins_d = NOP;
    tick();
    tick();
    ins_d = i_ins(6'h04, 5'd6, 5'd6, 16'd0);
    #1;
    n_cmp++; if (fwd_rs_d !== 2'd3) begin n_err++; $display("FAIL subuw_fwd_rs_d got %0d want 3", fwd_rs_d); end
    n_cmp++; if (fwd_rt_d !== 2'd3) begin n_err++; $display("FAIL subuw_fwd_rt_d got %0d want 3", fwd_rt_d); end
    drain();
  endtask

  task automatic test_store_fwd;
    ins_d = i_ins(6'h0d, 5'd0, 5'd4, 16'd5);
    tick();
    ins_d = i_ins(6'h2b, 5'd0, 5'd4, 16'd0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL orisw_stall got %0b want 0", stall); end
    tick();
    ins_d = NOP;
    #1;
    n_cmp++; if (fwd_rt_e !== 2'd2) begin n_err++; $display("FAIL orisw_fwd_rt_e got %0d want 2", fwd_rt_e); end
    n_cmp++; if (fwd_rs_e !== 2'd0) begin n_err++; $display("FAIL orisw_fwd_rs_e got %0d want 0", fwd_rs_e); end
    drain();
    ins_d = i_ins(6'h0f, 5'd0, 5'd7, 16'h1234);
    tick();
    ins_d = i_ins(6'h0d, 5'd7, 5'd8, 16'd1);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL luiori_stall got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL luiori_fwd_rs_d got %0d want 0", fwd_rs_d); end
    tick();
    ins_d = NOP;
    #1;
    n_cmp++; if (fwd_rs_e !== 2'd2) begin n_err++; $display("FAIL luiori_fwd_rs_e got %0d want 2", fwd_rs_e); end
    drain();
  endtask

  task automatic test_lw_store;
    ins_d = i_ins(6'h23, 5'd0, 5'd4, 16'd0);
    tick();
    ins_d = i_ins(6'h2b, 5'd0, 5'd4, 16'd0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lwsw_stall got %0b want 0", stall); end
    tick();
    ins_d = NOP;
    #1;
    n_cmp++; if (fwd_rt_e !== 2'd0) begin n_err++; $display("FAIL lwsw_fwd_rt_e got %0d want 0", fwd_rt_e); end
    n_cmp++; if (fwd_rt_m !== 1'b0) begin n_err++; $display("FAIL lwsw_fwd_rt_m_early got %0b want 0", fwd_rt_m); end
    tick();
    n_cmp++; if (fwd_rt_m !== 1'b1) begin n_err++; $display("FAIL lwsw_fwd_rt_m got %0b want 1", fwd_rt_m); end
    drain();
  endtask

  task automatic test_jal_jr;
    ins_d = JAL;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL jal_stall got %0b want 0", stall); end
    tick();
    ins_d = r_ins(5'd31, 5'd0, 5'd0, 6'h08);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL jr_stall got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd1) begin n_err++; $display("FAIL jr_fwd_rs_d got %0d want 1", fwd_rs_d); end
    tick();
    ins_d = NOP;
    #1;
    n_cmp++; if (dut.a3_m_q !== 5'd31) begin n_err++; $display("FAIL jal_a3_m got %0d want 31", dut.a3_m_q); end
    n_cmp++; if (fwd_rs_e !== 2'd2) begin n_err++; $display("FAIL jr_fwd_rs_e got %0d want 2", fwd_rs_e); end
    drain();
  endtask

  task automatic test_reg_zero;
    ins_d = r_ins(5'd1, 5'd2, 5'd0, 6'h21);
    tick();
    ins_d = i_ins(6'h04, 5'd0, 5'd0, 16'd0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL zero_fwd_rs_d got %0d want 0", fwd_rs_d); end
    n_cmp++; if (fwd_rt_d !== 2'd0) begin n_err++; $display("FAIL zero_fwd_rt_d got %0d want 0", fwd_rt_d); end
    drain();
    ins_d = i_ins(6'h23, 5'd0, 5'd0, 16'd0);
    tick();
    ins_d = r_ins(5'd0, 5'd0, 5'd1, 6'h21);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_lw_stall got %0b want 0", stall); end
    drain();
  endtask

  initial begin
    reset = 1'b0;
    ins_d = NOP;
    test_reset();
    test_lw_use();
    test_lw_branch();
    test_alu_branch();
    test_store_fwd();
    test_lw_store();
    test_jal_jr();
    test_reg_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
